// File: rtl/morse_key_classifier_if.sv
// Symbol stream carried from the key classifier to the downstream decoder.
// The classifier is the master (drives data/valid), the decoder is the slave.
interface morse_key_classifier_if;
   logic [1:0] sym_data;
   logic       sym_valid;
   logic       sym_ready;

   modport master (output sym_data, output sym_valid, input sym_ready);
   modport slave  (input sym_data, input sym_valid, output sym_ready);
endinterface

// File: rtl/morse_key_classifier.sv
// Morse key front end: synchronises and debounces a raw button, times press
// and release intervals, classifies them as dot / dash / letter gap / word gap
// and queues the symbols in a small FIFO offered on a valid/ready stream.
// Also drives a press-duration thermometer bar and an FSM state code.
module morse_key_classifier #(
   parameter int CNT_W        = 27,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int DOT_MIN      = 5_000_000,
   parameter int DASH_MIN     = 30_000_000,
   parameter int LETTER_GAP   = 30_000_000,
   parameter int WORD_GAP     = 70_000_000,
   parameter int FIFO_DEPTH   = 4,
   parameter int BAR_W        = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_in,
   morse_key_classifier_if.master sym_if,
   output logic                   overflow,
   input  logic                   clr_ovf,
   output logic                   key_level,
   output logic [BAR_W-1:0]       bar,
   output logic [1:0]             state_code
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int STEP_RAW = DASH_MIN / BAR_W;
   localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DOT_C      = CNT_W'(DOT_MIN);
   localparam logic [CNT_W-1:0] DASH_C     = CNT_W'(DASH_MIN);
   localparam logic [CNT_W-1:0] LGAP_LAST  = CNT_W'(LETTER_GAP - 1);
   localparam logic [CNT_W-1:0] WGAP_LAST  = CNT_W'(WORD_GAP - 1);
   localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP - 1);
   localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [BAR_W-1:0] BAR_MSB    = BAR_W'(1) << (BAR_W - 1);

   localparam logic [1:0] SYM_LGAP = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;
   localparam logic [1:0] SYM_WGAP = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2,
      ST_LGAP  = 2'd3
   } state_t;

   // Interval counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   logic              key_s1_q, key_s2_q;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic              key_level_q, key_level_d;
   logic              key_prev_q;
   logic              rise_q, rise_d, fall_q, fall_d;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  step_q, step_d;
   logic [BAR_W-1:0]  bar_q, bar_d;
   logic              push;
   logic [1:0]        push_sym;

   logic [1:0]        mem_q [FIFO_DEPTH];
   logic [1:0]        mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              full, pop, wr_en, drop;

   // Debounce: toggle the level after DEBOUNCE_CYC consecutive mismatching cycles.
   always_comb begin
      db_cnt_d    = '0;
      key_level_d = key_level_q;
      if (key_s2_q != key_level_q) begin
         if (db_cnt_q == DB_LAST) begin
            key_level_d = ~key_level_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
      rise_d = key_level_q & ~key_prev_q;
      fall_d = ~key_level_q & key_prev_q;
   end

   // Synchroniser, debouncer and registered edge detectors.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_s1_q    <= 1'b0;
         key_s2_q    <= 1'b0;
         db_cnt_q    <= '0;
         key_level_q <= 1'b0;
         key_prev_q  <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
      end else begin
         key_s1_q    <= key_in;
         key_s2_q    <= key_s1_q;
         db_cnt_q    <= db_cnt_d;
         key_level_q <= key_level_d;
         key_prev_q  <= key_level_q;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
      end
   end

   // Interval FSM: next state, counter, symbol push and progress bar.
   always_comb begin
      state_d  = state_q;
      cnt_d    = sat_inc(cnt_q);
      push     = 1'b0;
      push_sym = SYM_LGAP;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise_q) state_d = ST_PRESS;
         end
         ST_PRESS: begin
            if (fall_q) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               if (cnt_q >= DASH_C) begin
                  push     = 1'b1;
                  push_sym = SYM_DASH;
               end else if (cnt_q >= DOT_C) begin
                  push     = 1'b1;
                  push_sym = SYM_DOT;
               end
            end
         end
         ST_GAP: begin
            if (rise_q) begin
               state_d = ST_PRESS;
               cnt_d   = '0;
            end else if (cnt_q == LGAP_LAST) begin
               // Counter keeps running into LGAP so word-gap timing is measured
               // from the original release.
               state_d  = ST_LGAP;
               push     = 1'b1;
               push_sym = SYM_LGAP;
            end
         end
         default: begin
            if (rise_q) begin
               state_d = ST_PRESS;
               cnt_d   = '0;
            end else if (cnt_q == WGAP_LAST) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               push     = 1'b1;
               push_sym = SYM_WGAP;
            end
         end
      endcase

      // The bar sub-counter runs in lockstep with cnt, adding one MSB-first
      // segment every STEP cycles, so no divider is needed.
      step_d = '0;
      bar_d  = '0;
      if (state_q == ST_PRESS && state_d == ST_PRESS) begin
         if (step_q == STEP_LAST) begin
            bar_d = (bar_q >> 1) | BAR_MSB;
         end else begin
            step_d = step_q + CNT_W'(1);
            bar_d  = bar_q;
         end
      end
   end

   // FSM, interval counter and bar registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         bar_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         bar_q   <= bar_d;
      end
   end

   // FIFO bookkeeping: a push into a full FIFO survives only with a same-cycle pop.
   always_comb begin
      full  = (count_q == FIFO_FULL);
      pop   = sym_if.sym_valid & sym_if.sym_ready;
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;

      mem_d = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = push_sym;

      wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      if (drop)         ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
      else              ovf_d = ovf_q;
   end

   // Symbol storage; contents are qualified by the occupancy count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign sym_if.sym_valid = (count_q != '0);
   assign sym_if.sym_data  = sym_if.sym_valid ? mem_q[rd_ptr_q] : 2'b00;
   assign overflow         = ovf_q;
   assign key_level        = key_level_q;
   assign bar              = bar_q;
   assign state_code       = state_q;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Scoreboard bench for morse_key_classifier with small timing parameters.
module tb_morse_key_classifier;
   localparam int BAR_W = 4;

   logic             clk     = 1'b0;
   logic             reset   = 1'b0;
   logic             key_in  = 1'b0;
   logic             clr_ovf = 1'b0;
   logic             overflow, key_level;
   logic [BAR_W-1:0] bar;
   logic [1:0]       state_code;

   morse_key_classifier_if sym_if ();

   morse_key_classifier #(
      .CNT_W(27), .DEBOUNCE_CYC(4), .DOT_MIN(10), .DASH_MIN(40),
      .LETTER_GAP(40), .WORD_GAP(100), .FIFO_DEPTH(4), .BAR_W(BAR_W)
   ) dut (
      .clk(clk), .reset(reset), .key_in(key_in), .sym_if(sym_if),
      .overflow(overflow), .clr_ovf(clr_ovf), .key_level(key_level),
      .bar(bar), .state_code(state_code)
   );

   always #5 clk = ~clk;

   int         vectors      = 0;
   int         miscompares  = 0;
   int         valid_cycles = 0;
   logic [1:0] exp_q [$];

   // Monitor: every presented head symbol must match the oldest expected one.
   always @(negedge clk) begin
      if (reset && sym_if.sym_valid) begin
         valid_cycles++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sym_unexpected: got %b, required no symbol", sym_if.sym_data);
         end else begin
            if (sym_if.sym_data !== exp_q[0]) begin
               miscompares++;
               $display("FAIL sym_data: got %b, required %b", sym_if.sym_data, exp_q[0]);
            end
            if (sym_if.sym_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic dot_press();
      key_in = 1'b1; step(25);
      key_in = 1'b0; step(35);
   endtask

   int vc;
   logic seen;

   initial begin
      sym_if.sym_ready = 1'b1;
      step(3);
      check("rst_sym_valid",  32'(sym_if.sym_valid), 32'd0);
      check("rst_sym_data",   32'(sym_if.sym_data),  32'd0);
      check("rst_overflow",   32'(overflow),         32'd0);
      check("rst_key_level",  32'(key_level),        32'd0);
      check("rst_bar",        32'(bar),              32'd0);
      check("rst_state_code", 32'(state_code),       32'd0);
      reset = 1'b1;
      step(2);

      // Dot, letter gap, word gap.
      exp_q.push_back(2'b01); exp_q.push_back(2'b00); exp_q.push_back(2'b11);
      vc = valid_cycles;
      key_in = 1'b1; step(15);
      check("dot_state_press", 32'(state_code), 32'd1);
      check("dot_key_level",   32'(key_level),  32'd1);
      step(5);
      key_in = 1'b0; step(20);
      check("dot_state_gap",   32'(state_code), 32'd2);
      step(40);
      check("dot_state_lgap",  32'(state_code), 32'd3);
      step(90);
      check("dot_state_idle",  32'(state_code), 32'd0);
      check("dot_valid_pulses", 32'(valid_cycles - vc), 32'd3);

      // Dash and progress bar.
      exp_q.push_back(2'b10); exp_q.push_back(2'b00); exp_q.push_back(2'b11);
      key_in = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         step(1);
         if (i == 13) check("bar_k5",  32'(bar), 32'h0);
         if (i == 23) check("bar_k15", 32'(bar), 32'h8);
         if (i == 33) check("bar_k25", 32'(bar), 32'hC);
         if (i == 43) check("bar_k35", 32'(bar), 32'hE);
         if (i == 53) check("bar_k45", 32'(bar), 32'hF);
         if (i == 58) check("bar_k50", 32'(bar), 32'hF);
      end
      key_in = 1'b0; step(10);
      check("bar_after_release", 32'(bar), 32'h0);
      step(140);
      check("dash_state_idle", 32'(state_code), 32'd0);

      // Glitch rejection: 3-cycle pulse never reaches key_level.
      key_in = 1'b1; step(3);
      key_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         seen = seen | key_level;
      end
      check("glitch_key_level", 32'(seen), 32'd0);
      check("glitch_state", 32'(state_code), 32'd0);

      // Short press: no symbol, but gap timing starts from its release.
      exp_q.push_back(2'b00); exp_q.push_back(2'b11);
      vc = valid_cycles;
      key_in = 1'b1; step(6);
      key_in = 1'b0; step(12);
      check("short_state_gap", 32'(state_code), 32'd2);
      step(30);
      check("short_no_symbol_yet", 32'(valid_cycles - vc), 32'd0);
      step(108);
      check("short_gap_symbols", 32'(valid_cycles - vc), 32'd2);
      check("short_state_idle", 32'(state_code), 32'd0);

      // Backpressure: four dots fit, everything after is dropped.
      sym_if.sym_ready = 1'b0;
      for (int d = 0; d < 5; d++) begin
         if (d < 4) exp_q.push_back(2'b01);
         dot_press();
      end
      step(115);
      check("bp_overflow", 32'(overflow), 32'd1);
      check("bp_valid",    32'(sym_if.sym_valid), 32'd1);
      vc = valid_cycles;
      sym_if.sym_ready = 1'b1; step(8);
      check("bp_drain_count", 32'(valid_cycles - vc), 32'd4);
      check("bp_empty",       32'(sym_if.sym_valid), 32'd0);
      check("bp_ovf_sticky",  32'(overflow), 32'd1);
      clr_ovf = 1'b1; step(1);
      clr_ovf = 1'b0;
      check("bp_clr_ovf", 32'(overflow), 32'd0);

      // Full FIFO with a pop in the same cycle as the dot push.
      sym_if.sym_ready = 1'b0;
      for (int d = 0; d < 5; d++) exp_q.push_back(2'b01);
      for (int d = 0; d < 4; d++) dot_press();
      key_in = 1'b1; step(25);
      key_in = 1'b0; step(7);
      sym_if.sym_ready = 1'b1; step(1);
      sym_if.sym_ready = 1'b0; step(12);
      check("full_pp_overflow", 32'(overflow), 32'd0);
      check("full_pp_valid",    32'(sym_if.sym_valid), 32'd1);
      step(27);
      clr_ovf = 1'b1; step(1);
      clr_ovf = 1'b0;
      check("ovf_set_wins", 32'(overflow), 32'd1);
      step(102);
      vc = valid_cycles;
      sym_if.sym_ready = 1'b1; step(8);
      check("full_pp_drain_count", 32'(valid_cycles - vc), 32'd4);

      // Reset in the middle of a press with a symbol pending.
      sym_if.sym_ready = 1'b0;
      exp_q.push_back(2'b01);
      dot_press();
      key_in = 1'b1; step(30);
      reset = 1'b0;
      #1;
      check("mid_rst_sym_valid", 32'(sym_if.sym_valid), 32'd0);
      check("mid_rst_sym_data",  32'(sym_if.sym_data),  32'd0);
      check("mid_rst_overflow",  32'(overflow),         32'd0);
      check("mid_rst_key_level", 32'(key_level),        32'd0);
      check("mid_rst_bar",       32'(bar),              32'd0);
      check("mid_rst_state",     32'(state_code),       32'd0);
      exp_q.delete();
      step(3);
      reset = 1'b1;
      sym_if.sym_ready = 1'b1;
      exp_q.push_back(2'b01); exp_q.push_back(2'b00); exp_q.push_back(2'b11);
      step(15);
      check("post_rst_press", 32'(state_code), 32'd1);
      check("post_rst_level", 32'(key_level),  32'd1);
      step(15);
      key_in = 1'b0; step(150);
      check("post_rst_idle", 32'(state_code), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
